// File: rtl/video_timing.sv
// Raster timing generator.
// Two counters (hc, vc) walk the full line/frame; every output is a registered
// decode of the counter values held before the edge, so outputs trail the
// counters by exactly one clock. Dropping enable (or reset) parks the counters
// on the last position of the frame, so the next enabled edge always begins a
// fresh frame with start_of_screen and start_of_line asserted together.
module video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       display_start_of_screen,
  output logic       display_start_of_line,
  output logic       display_next_pixel,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vblank_pulse,
  output logic [9:0] x,
  output logic [9:0] y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HC_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_hc;
  logic [9:0] r_vc;

  logic w_hc_last;
  logic w_vc_last;
  logic w_active;
  logic w_sol;
  logic w_sos;
  logic w_hsync;
  logic w_vsync;
  logic w_vblank;

  assign w_hc_last = (r_hc == HC_LAST);
  assign w_vc_last = (r_vc == VC_LAST);
  assign w_active  = (r_hc < H_ACT) && (r_vc < V_ACT);
  // The strobe fires on the last clock of the preceding line, so the frame's
  // final line (vc == V_TOTAL-1) announces active line 0.
  assign w_sol     = w_hc_last && (w_vc_last || (r_vc < V_ACT_M1));
  assign w_sos     = w_hc_last && w_vc_last;
  assign w_hsync   = (r_hc >= HS_START) && (r_hc < HS_END);
  assign w_vsync   = (r_vc >= VS_START) && (r_vc < VS_END);
  assign w_vblank  = (r_hc == 10'd0) && (r_vc == V_ACT);

  // Position counters; parked on the last frame position while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hc <= HC_LAST;
      r_vc <= VC_LAST;
    end else if (!enable) begin
      r_hc <= HC_LAST;
      r_vc <= VC_LAST;
    end else begin
      r_hc <= w_hc_last ? 10'd0 : r_hc + 10'd1;
      if (w_hc_last) begin
        r_vc <= w_vc_last ? 10'd0 : r_vc + 10'd1;
      end
    end
  end

  // Registered decode of the pre-edge counter values; forced idle when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      display_start_of_screen <= 1'b0;
      display_start_of_line   <= 1'b0;
      display_next_pixel      <= 1'b0;
      active                  <= 1'b0;
      hsync_n                 <= 1'b1;
      vsync_n                 <= 1'b1;
      vblank_pulse            <= 1'b0;
      x                       <= 10'd0;
      y                       <= 10'd0;
    end else if (!enable) begin
      display_start_of_screen <= 1'b0;
      display_start_of_line   <= 1'b0;
      display_next_pixel      <= 1'b0;
      active                  <= 1'b0;
      hsync_n                 <= 1'b1;
      vsync_n                 <= 1'b1;
      vblank_pulse            <= 1'b0;
      x                       <= 10'd0;
      y                       <= 10'd0;
    end else begin
      display_start_of_screen <= w_sos;
      display_start_of_line   <= w_sol;
      display_next_pixel      <= w_active;
      active                  <= w_active;
      hsync_n                 <= ~w_hsync;
      vsync_n                 <= ~w_vsync;
      vblank_pulse            <= w_vblank;
      x                       <= r_hc;
      y                       <= r_vc;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-size instance and a tiny 14x7 instance run
// side by side from shared clk/rst/enable. The reference treats the raster as
// a linear position index derived from how many consecutive enabled edges
// have elapsed, and decodes each output from that with plain arithmetic.
module tb_video_timing;

  typedef struct packed {
    logic       sos;
    logic       sol;
    logic       dnp;
    logic       act;
    logic       hs;
    logic       vs;
    logic       vb;
    logic [9:0] x;
    logic [9:0] y;
  } out_t;

  typedef struct packed {
    logic en;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;

  logic       d_sos, d_sol, d_dnp, d_act, d_hs, d_vs, d_vb;
  logic [9:0] d_x, d_y;
  logic       s_sos, s_sol, s_dnp, s_act, s_hs, s_vs, s_vb;
  logic [9:0] s_x, s_y;
  out_t d_out, s_out;

  int errors = 0;
  int checks = 0;
  int n_run = 0;

  always #5 clk = ~clk;

  video_timing u_def (
    .clk(clk), .rst(rst), .enable(enable),
    .display_start_of_screen(d_sos), .display_start_of_line(d_sol),
    .display_next_pixel(d_dnp), .active(d_act), .hsync_n(d_hs),
    .vsync_n(d_vs), .vblank_pulse(d_vb), .x(d_x), .y(d_y)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk(clk), .rst(rst), .enable(enable),
    .display_start_of_screen(s_sos), .display_start_of_line(s_sol),
    .display_next_pixel(s_dnp), .active(s_act), .hsync_n(s_hs),
    .vsync_n(s_vs), .vblank_pulse(s_vb), .x(s_x), .y(s_y)
  );

  assign d_out = {d_sos, d_sol, d_dnp, d_act, d_hs, d_vs, d_vb, d_x, d_y};
  assign s_out = {s_sos, s_sol, s_dnp, s_act, s_hs, s_vs, s_vb, s_x, s_y};

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // n = number of consecutive enabled edges including this one. The outputs
  // show the position one step behind the counters, and the first enabled
  // edge shows the final position of the frame (index tot-1).
  function automatic out_t model(int ha, int hf, int hsy, int hb,
                                 int va, int vf, int vsy, int vbp,
                                 int n, logic run);
    out_t o;
    int ht, vt, tot, pos, px, py;
    o = idle_out();
    if (!run) return o;
    ht  = ha + hf + hsy + hb;
    vt  = va + vf + vsy + vbp;
    tot = ht * vt;
    pos = ((n - 2) % tot + tot) % tot;
    px  = pos % ht;
    py  = pos / ht;
    o.act = (px < ha) && (py < va);
    o.dnp = o.act;
    o.sol = (px == ht - 1) && ((py == vt - 1) || (py < va - 1));
    o.sos = (px == ht - 1) && (py == vt - 1);
    o.hs  = !((px >= ha + hf) && (px < ha + hf + hsy));
    o.vs  = !((py >= va + vf) && (py < va + vf + vsy));
    o.vb  = (px == 0) && (py == va);
    o.x   = 10'(px);
    o.y   = 10'(py);
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input out_t got, input out_t exp);
    chk({tag, ".sos"}, int'(got.sos), int'(exp.sos));
    chk({tag, ".sol"}, int'(got.sol), int'(exp.sol));
    chk({tag, ".dnp"}, int'(got.dnp), int'(exp.dnp));
    chk({tag, ".active"}, int'(got.act), int'(exp.act));
    chk({tag, ".hsync_n"}, int'(got.hs), int'(exp.hs));
    chk({tag, ".vsync_n"}, int'(got.vs), int'(exp.vs));
    chk({tag, ".vblank"}, int'(got.vb), int'(exp.vb));
    chk({tag, ".x"}, int'(got.x), int'(exp.x));
    chk({tag, ".y"}, int'(got.y), int'(exp.y));
  endtask

  // One clock: advance the reference, then compare both instances.
  task automatic step();
    logic run;
    @(posedge clk);
    #1;
    run = rst && enable;
    if (run) n_run++;
    else n_run = 0;
    cmp("def", d_out, model(640, 16, 96, 48, 480, 10, 2, 33, n_run, run));
    cmp("small", s_out, model(8, 2, 2, 2, 4, 1, 1, 1, n_run, run));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    int sol_cnt, vb_cnt, pix_cnt, period, frames, hs_low, hs_first;
    logic p_sos, p_sol, p_vb, found;

    // en | sos sol dnp act hs vs vb x y   (small 14x7 instance)
    vecs[0] = '{1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd13, 10'd6}};
    vecs[1] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}};
    vecs[2] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1, 10'd0}};
    vecs[3] = '{1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}};
    vecs[4] = '{1'b0, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}};
    vecs[5] = '{1'b1, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd13, 10'd6}};
    vecs[6] = '{1'b1, '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}};

    do_reset();
    cmp("reset_def", d_out, idle_out());
    cmp("reset_small", s_out, idle_out());

    for (int i = 0; i < 7; i++) begin
      enable = vecs[i].en;
      step();
      cmp($sformatf("vec%0d", i), s_out, vecs[i].exp);
    end

    // Small instance: free-run three frames, tally strobes per frame.
    do_reset();
    enable = 1'b1;
    sol_cnt = 0; vb_cnt = 0; pix_cnt = 0; period = 0; frames = 0;
    p_sos = 1'b0; p_sol = 1'b0; p_vb = 1'b0;
    for (int c = 0; c < 295; c++) begin
      step();
      period++;
      if (s_sos) begin
        chk("sos_with_sol", int'(s_sol), 1);
        if (frames > 0) begin
          chk("frame_period", period, 98);
          chk("frame_sol", sol_cnt, 4);
          chk("frame_vblank", vb_cnt, 1);
          chk("frame_pixels", pix_cnt, 32);
        end
        frames++;
        period = 0; sol_cnt = 0; vb_cnt = 0; pix_cnt = 0;
      end
      chk("no_double_sos", int'(s_sos & p_sos), 0);
      chk("no_double_sol", int'(s_sol & p_sol), 0);
      chk("no_double_vb", int'(s_vb & p_vb), 0);
      p_sos = s_sos; p_sol = s_sol; p_vb = s_vb;
      sol_cnt += int'(s_sol);
      vb_cnt  += int'(s_vb);
      pix_cnt += int'(s_dnp);
    end
    chk("frames_seen", frames, 4);

    // Default instance: first line after release.
    do_reset();
    enable = 1'b1;
    step();
    chk("first_sos", int'(d_sos), 1);
    chk("first_sol", int'(d_sol), 1);
    for (int i = 0; i < 640; i++) begin
      step();
      chk("line0_x", int'(d_x), i);
      chk("line0_y", int'(d_y), 0);
      chk("line0_dnp", int'(d_dnp), 1);
    end
    step();
    chk("edge642_active", int'(d_act), 0);
    hs_low = 0; hs_first = -1;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) step();
      if (!d_hs) begin
        if (hs_first < 0) hs_first = int'(d_x);
        hs_low++;
      end
    end
    chk("hsync_low_cycles", hs_low, 96);
    chk("hsync_first_x", hs_first, 656);

    // Async reset asserted between edges mid-line.
    for (int i = 0; i < 37; i++) step();
    #3 rst = 1'b0;
    #1;
    cmp("async_rst_def", d_out, idle_out());
    cmp("async_rst_small", s_out, idle_out());
    step();
    rst = 1'b1;
    step();
    chk("rst_recover_sos", int'(d_sos), 1);
    step();
    chk("rst_recover_x0", int'(d_x), 0);

    // Abort mid-frame at x=300, y=10, then resume.
    do_reset();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 9000 && !found; i++) begin
      step();
      if (d_x == 10'd300 && d_y == 10'd10) found = 1'b1;
    end
    chk("reach_x300_y10", int'(found), 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("abort_idle", d_out, idle_out());
    end
    enable = 1'b1;
    step();
    chk("resume_sos", int'(d_sos), 1);
    chk("resume_x", int'(d_x), 799);
    step();
    chk("resume_pixel0", int'(d_x) + int'(d_y), 0);

    // Randomized enable drops and resets against the reference.
    for (int i = 0; i < 30000; i++) begin
      enable = ($urandom_range(63) != 0);
      rst = ($urandom_range(499) != 0);
      step();
    end
    rst = 1'b1;
    enable = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
